// File: rtl/router_wrap_pkg.sv
// Shared types and helpers for the router_wrap slice.
//   olck_state_e  : output-lock arbiter state encoding
//   ROUTER_NUM_IN : default number of input requesters per output port
//   onehot()      : binary index -> one-hot vector (32 bits; callers cast down)
package router_wrap_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } olck_state_e;

  localparam int unsigned ROUTER_NUM_IN = 4;

  function automatic logic [31:0] onehot(input int unsigned idx);
    onehot = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/router_wrap_rr_pick.sv
// Combinational round-robin picker.
//   req        : per-input request vector
//   rr_ptr     : highest-priority input for this pick
//   any        : at least one request present
//   winner_idx : first requesting input at or after rr_ptr, wrapping; 0 if none
module router_wrap_rr_pick #(
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic              any,
  output logic [IDX_W-1:0]  winner_idx
);

  always_comb begin
    int unsigned idx;
    idx        = 0;
    any        = 1'b0;
    winner_idx = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_IN;
      if (!any && req[idx]) begin
        any        = 1'b1;
        winner_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/router_wrap_slice_olck_arbiter.sv
// Per-output-port lock arbiter. Round-robin grants one input, holds the lock
// from head to tail flit, and drives olck_d into the output-lock flop.
//   clk       : fabric clock
//   reset     : synchronous, active-low
//   req       : per-input head-flit request
//   tail      : per-input "current flit is tail"
//   flit_fire : granted input moves one flit this cycle
//   flush     : synchronous lock abort, keeps round-robin pointer
//   gnt       : registered one-hot grant, zero when unlocked
//   gnt_idx   : binary index of gnt, zero when unlocked
//   olck_d    : lock state, D input of the output-lock flop
//   busy      : same as olck_d, monitor tap
module router_wrap_slice_olck_arbiter
  import router_wrap_pkg::*;
#(
  parameter  int unsigned NUM_IN = ROUTER_NUM_IN,
  localparam int unsigned IDX_W  = $clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] tail,
  input  logic              flit_fire,
  input  logic              flush,
  output logic [NUM_IN-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              olck_d,
  output logic              busy
);

  olck_state_e       state_q, state_n;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_n;
  logic [NUM_IN-1:0] gnt_q, gnt_n;
  logic [IDX_W-1:0]  idx_q, idx_n;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;

  router_wrap_rr_pick #(
    .NUM_IN (NUM_IN)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .any        (pick_any),
    .winner_idx (pick_idx)
  );

  always_comb begin
    state_n  = state_q;
    rr_ptr_n = rr_ptr_q;
    gnt_n    = gnt_q;
    idx_n    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_n = LOCKED;
          gnt_n   = NUM_IN'(onehot(32'(pick_idx)));
          idx_n   = pick_idx;
        end
      end
      LOCKED: begin
        if (flit_fire && tail[idx_q]) begin
          state_n  = IDLE;
          gnt_n    = '0;
          idx_n    = '0;
          rr_ptr_n = (idx_q == IDX_W'(NUM_IN - 1)) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        idx_n   = '0;
      end
    endcase
    // Flush overrides any grant or release, including the pointer advance.
    if (flush) begin
      state_n  = IDLE;
      gnt_n    = '0;
      idx_n    = '0;
      rr_ptr_n = rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_n;
      rr_ptr_q <= rr_ptr_n;
      gnt_q    <= gnt_n;
      idx_q    <= idx_n;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign olck_d  = (state_q == LOCKED);
  assign busy    = (state_q == LOCKED);

endmodule

// File: tb/tb_router_wrap_slice_olck_arbiter.sv
module tb_router_wrap_slice_olck_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] tail;
  logic       flit_fire;
  logic       flush;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       olck_d;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Expected grant indices, pushed when a request is presented, popped on lock rise.
  int unsigned exp_q[$];
  logic        prev_olck = 1'b0;

  router_wrap_slice_olck_arbiter #(
    .NUM_IN (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .tail      (tail),
    .flit_fire (flit_fire),
    .flush     (flush),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .olck_d    (olck_d),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle invariants and scoreboard pop on each new lock.
  always @(negedge clk) begin
    logic [3:0] exp_gnt;
    total++;
    if (!($countones(gnt) <= 1) || (olck_d !== |gnt) || (busy !== olck_d)) begin
      bad++;
      $display("FAIL invariant: gnt=%b olck_d=%b busy=%b", gnt, olck_d, busy);
    end
    total++;
    if (!olck_d && gnt_idx !== 2'd0) begin
      bad++;
      $display("FAIL idx_when_idle: got %0d want 0", gnt_idx);
    end
    if (olck_d && !prev_olck) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_grant: got idx %0d want no grant", gnt_idx);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        exp_gnt = 4'b0001 << e;
        if (gnt_idx !== 2'(e) || gnt !== exp_gnt) begin
          bad++;
          $display("FAIL sb_grant: got idx=%0d gnt=%b want idx=%0d gnt=%b",
                   gnt_idx, gnt, e, exp_gnt);
        end
      end
    end
    prev_olck = olck_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 4'b0; tail = 4'b0; flit_fire = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    req = 4'b1111;
    do_reset();
    total++;
    if (gnt !== 4'b0 || olck_d !== 1'b0 || gnt_idx !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b idx=%0d olck=%b busy=%b want all 0",
               gnt, gnt_idx, olck_d, busy);
    end
    req = 4'b0100;
    exp_q.push_back(2);
    tick();
    total++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || olck_d !== 1'b1) begin
      bad++;
      $display("FAIL first_grant: gnt=%b idx=%0d olck=%b want 0100/2/1",
               gnt, gnt_idx, olck_d);
    end
    req = 4'b0; tail = 4'b0100; flit_fire = 1'b1;
    tick();
    total++;
    if (olck_d !== 1'b0) begin
      bad++;
      $display("FAIL first_release: olck=%b want 0", olck_d);
    end
    idle_inputs();
  endtask

  task automatic test_rr_fairness();
    int unsigned order[5] = '{0, 1, 2, 3, 0};
    idle_inputs();
    do_reset();
    req = 4'b1111; tail = 4'b1111; flit_fire = 1'b1;
    foreach (order[k]) exp_q.push_back(order[k]);
    foreach (order[k]) begin
      tick();
      total++;
      if (olck_d !== 1'b1 || gnt_idx !== 2'(order[k])) begin
        bad++;
        $display("FAIL rr_grant%0d: olck=%b idx=%0d want 1/%0d", k, olck_d, gnt_idx, order[k]);
      end
      tick();
      total++;
      if (olck_d !== 1'b0 || gnt !== 4'b0) begin
        bad++;
        $display("FAIL rr_bubble%0d: olck=%b gnt=%b want 0/0000", k, olck_d, gnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    idle_inputs();
    req = 4'b1000;
    exp_q.push_back(3);
    tick();
    total++;
    if (gnt_idx !== 2'd3 || olck_d !== 1'b1) begin
      bad++;
      $display("FAIL wrap_lock3: idx=%0d olck=%b want 3/1", gnt_idx, olck_d);
    end
    req = 4'b1001; tail = 4'b1000; flit_fire = 1'b1;
    exp_q.push_back(0);
    tick();
    total++;
    if (olck_d !== 1'b0) begin
      bad++;
      $display("FAIL wrap_release: olck=%b want 0", olck_d);
    end
    tail = 4'b0; flit_fire = 1'b0;
    tick();
    total++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      bad++;
      $display("FAIL wrap_next: gnt=%b idx=%0d want 0001/0", gnt, gnt_idx);
    end
    req = 4'b0; tail = 4'b0001; flit_fire = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_multi_flit();
    idle_inputs();
    req = 4'b0010;
    exp_q.push_back(1);
    tick();
    // Request drops, other inputs' tails asserted: both must be ignored.
    req = 4'b0000; tail = 4'b1101; flit_fire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (olck_d !== 1'b1 || gnt !== 4'b0010) begin
        bad++;
        $display("FAIL body_fire%0d: olck=%b gnt=%b want 1/0010", i, olck_d, gnt);
      end
    end
    tail = 4'b0010; flit_fire = 1'b0;
    tick();
    total++;
    if (olck_d !== 1'b1 || gnt_idx !== 2'd1) begin
      bad++;
      $display("FAIL tail_no_fire: olck=%b idx=%0d want 1/1", olck_d, gnt_idx);
    end
    flit_fire = 1'b1;
    tick();
    total++;
    if (olck_d !== 1'b0 || gnt !== 4'b0) begin
      bad++;
      $display("FAIL multi_release: olck=%b gnt=%b want 0/0000", olck_d, gnt);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    idle_inputs();
    req = 4'b0100;
    exp_q.push_back(2);
    tick();
    req = 4'b0; tail = 4'b0100; flit_fire = 1'b1; flush = 1'b1;
    tick();
    total++;
    if (olck_d !== 1'b0 || gnt !== 4'b0) begin
      bad++;
      $display("FAIL flush_release: olck=%b gnt=%b want 0/0000", olck_d, gnt);
    end
    // Pointer must still be 2: with all requesting, 2 wins rather than 3.
    idle_inputs();
    req = 4'b1111;
    exp_q.push_back(2);
    tick();
    total++;
    if (gnt_idx !== 2'd2 || olck_d !== 1'b1) begin
      bad++;
      $display("FAIL flush_ptr_kept: idx=%0d olck=%b want 2/1", gnt_idx, olck_d);
    end
    req = 4'b0; flush = 1'b1;
    tick();
    req = 4'b1111;
    tick();
    total++;
    if (olck_d !== 1'b0) begin
      bad++;
      $display("FAIL flush_blocks_grant: olck=%b want 0", olck_d);
    end
    flush = 1'b0;
    exp_q.push_back(2);
    tick();
    total++;
    if (gnt_idx !== 2'd2 || olck_d !== 1'b1) begin
      bad++;
      $display("FAIL flush_regrant: idx=%0d olck=%b want 2/1", gnt_idx, olck_d);
    end
    req = 4'b0; tail = 4'b0100; flit_fire = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    idle_inputs();
    req = 4'b0010;
    exp_q.push_back(1);
    tick();
    total++;
    if (gnt_idx !== 2'd1 || olck_d !== 1'b1) begin
      bad++;
      $display("FAIL midpkt_lock: idx=%0d olck=%b want 1/1", gnt_idx, olck_d);
    end
    reset = 1'b0; flit_fire = 1'b1; flush = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b0 || gnt_idx !== 2'd0 || olck_d !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midpkt_reset: gnt=%b idx=%0d olck=%b busy=%b want all 0",
               gnt, gnt_idx, olck_d, busy);
    end
    reset = 1'b1;
    idle_inputs();
    req = 4'b1111;
    exp_q.push_back(0);
    tick();
    total++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      bad++;
      $display("FAIL midpkt_ptr_reset: gnt=%b idx=%0d want 0001/0", gnt, gnt_idx);
    end
    req = 4'b0; tail = 4'b0001; flit_fire = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_rr_fairness();
    test_wrap();
    test_multi_flit();
    test_flush();
    test_reset_mid_packet();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
